// File: rtl/wb_spi_master.sv
// wb_spi_master: Wishbone-controlled SPI mode-0 master, 8-bit MSB-first transfers,
// programmable SCK half-period and four software-driven chip selects.
module wb_spi_master #(
  parameter logic [15:0] default_div = 16'd4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  output logic        intr,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic [3:0]  spi_cs_n
);
  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;
  state_t r_state, w_next;
  logic        r_ack, r_sck, r_mosi, r_done, r_ovr, r_ie;
  logic [31:0] r_dat;
  logic [15:0] r_div, r_cnt;
  logic [3:0]  r_cs;
  logic [7:0]  r_shift, r_rx;
  logic [2:0]  r_bits;
  logic        w_acc, w_wr, w_rd_data, w_busy, w_zero, w_start, w_rise, w_fall, w_fin;
  logic [1:0]  w_adr;
  logic [31:0] w_rdata;
  logic        w_unused;
  assign w_unused  = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:16]};
  assign w_adr     = wb_adr_i[3:2];
  assign w_acc     = wb_stb_i & wb_cyc_i & ~r_ack;
  assign w_wr      = w_acc & wb_we_i;
  assign w_rd_data = w_acc & ~wb_we_i & (w_adr == 2'd0);
  assign w_busy    = r_state != IDLE;
  assign w_zero    = r_cnt == 16'd0;
  assign w_start   = w_wr & (w_adr == 2'd0) & ~w_busy;
  assign w_rise    = (r_state == LOW) & w_zero;
  assign w_fall    = (r_state == HIGH) & w_zero & (r_bits != 3'd7);
  assign w_fin     = (r_state == HIGH) & w_zero & (r_bits == 3'd7);
  always_comb begin
    w_next  = r_state;
    w_next  = r_state == IDLE ? (w_start ? LOW : IDLE) :
              r_state == LOW  ? (w_zero ? HIGH : LOW) :
              w_zero ? (r_bits == 3'd7 ? IDLE : LOW) : HIGH;
    w_rdata = w_adr == 2'd0 ? {24'd0, r_rx} :
              w_adr == 2'd1 ? {28'd0, r_ie, r_ovr, r_done, w_busy} :
              w_adr == 2'd2 ? {16'd0, r_div} : {28'd0, r_cs};
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ack   <= 1'b0;
      r_dat   <= 32'd0;
      r_div   <= default_div;
      r_cnt   <= 16'd0;
      r_cs    <= 4'd0;
      r_ie    <= 1'b0;
      r_ovr   <= 1'b0;
      r_done  <= 1'b0;
      r_sck   <= 1'b0;
      r_mosi  <= 1'b0;
      r_shift <= 8'd0;
      r_bits  <= 3'd0;
      r_rx    <= 8'd0;
    end else begin
      r_ack   <= w_acc;
      r_dat   <= w_acc ? w_rdata : 32'd0;
      if (w_wr && w_adr == 2'd2) r_div <= wb_dat_i[15:0];
      if (w_wr && w_adr == 2'd3) r_cs <= wb_dat_i[3:0];
      if (w_wr && w_adr == 2'd1) r_ie <= wb_dat_i[3];
      if (w_wr && w_adr == 2'd0 && w_busy) r_ovr <= 1'b1;
      else if (w_wr && w_adr == 2'd1 && wb_dat_i[2]) r_ovr <= 1'b0;
      // completion beats a coincident DATA read or W1C
      r_done  <= w_fin | (r_done & ~w_start & ~w_rd_data & ~(w_wr & (w_adr == 2'd1) & wb_dat_i[1]));
      r_cnt   <= w_start ? r_div : !w_busy ? r_cnt : w_zero ? r_div : r_cnt - 16'd1;
      r_sck   <= w_next == HIGH;
      r_mosi  <= w_start ? wb_dat_i[7] : w_fall ? r_shift[7] : r_mosi;
      r_shift <= w_start ? wb_dat_i[7:0] : w_rise ? {r_shift[6:0], spi_miso} : r_shift;
      r_bits  <= w_start ? 3'd0 : w_fall ? r_bits + 3'd1 : r_bits;
      if (w_fin) r_rx <= r_shift;
    end
  end
  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_dat;
  assign intr     = r_ie & r_done;
  assign spi_sck  = r_sck;
  assign spi_mosi = r_mosi;
  assign spi_cs_n = ~r_cs;
endmodule
